// File: rtl/gen3_descramble_sequencer_pkg.sv
// Shared types and constants for the RX descrambler sequencer.
// Holds the block classes, the sync header codes, the ordered-set identifiers,
// the 8b/10b K codes and small helpers that decode the PIPE datapath width.
package gen3_descramble_sequencer_pkg;

  localparam int unsigned SymPerBlock = 16;
  localparam int unsigned BlkCntW     = 4;

  typedef enum logic [2:0] {
    BtNone    = 3'd0,
    BtData    = 3'd1,
    BtEieos   = 3'd2,
    BtSkp     = 3'd3,
    BtTs      = 3'd4,
    BtOtherOs = 3'd5,
    BtErr     = 3'd6
  } block_type_e;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StInBlock = 1'b1
  } state_e;

  localparam logic [1:0] SyncData = 2'b01;
  localparam logic [1:0] SyncOs   = 2'b10;

  localparam logic [7:0] OsIdEieos = 8'h00;
  localparam logic [7:0] OsIdSkp   = 8'hAA;
  localparam logic [7:0] OsIdTs1   = 8'h1E;
  localparam logic [7:0] OsIdTs2   = 8'h2D;
  localparam logic [7:0] OsIdEios  = 8'h66;
  localparam logic [7:0] OsIdSds   = 8'hE1;
  localparam logic [7:0] OsIdFts   = 8'h55;

  localparam logic [7:0] KCom = 8'hBC;
  localparam logic [7:0] KSkp = 8'h1C;

  // Symbols per beat; unsupported widths give zero lanes.
  function automatic logic [2:0] lanes_of_width(input logic [5:0] width);
    case (width)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] n_lanes);
    case (n_lanes)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] lfsr_sel_of_width(input logic [5:0] width);
    case (width)
      6'd16:   return 2'd1;
      6'd32:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/gen3_descramble_sequencer_if.sv
// PIPE RX side inputs and descrambler control outputs of the sequencer.
// slave: the sequencer (consumes PIPE RX, drives LFSR controls).
// master: the environment driving PIPE RX and observing the controls.
interface gen3_descramble_sequencer_if;
  logic [2:0]  gen;
  logic [5:0]  pipe_width;
  logic        turn_off;
  logic        pipe_data_valid;
  logic        pipe_start_block;
  logic [1:0]  pipe_sync_header;
  logic [31:0] pipe_data;
  logic [3:0]  pipe_data_k;
  logic [1:0]  lfsr_sel;
  logic [3:0]  advance;
  logic [3:0]  descramble_en;
  logic        lfsr_reset;
  logic [2:0]  block_type;
  logic [3:0]  symbol_index;
  logic        block_error;

  modport slave (
    input  gen, pipe_width, turn_off, pipe_data_valid, pipe_start_block,
           pipe_sync_header, pipe_data, pipe_data_k,
    output lfsr_sel, advance, descramble_en, lfsr_reset, block_type,
           symbol_index, block_error
  );

  modport master (
    output gen, pipe_width, turn_off, pipe_data_valid, pipe_start_block,
           pipe_sync_header, pipe_data, pipe_data_k,
    input  lfsr_sel, advance, descramble_en, lfsr_reset, block_type,
           symbol_index, block_error
  );
endinterface

// File: rtl/gen3_descramble_sequencer_os_classifier.sv
// Combinational block classifier.
// sync_header_i : 128b/130b sync header of the start beat
// sym0_i        : lane-0 symbol of the start beat
// block_type_o  : decoded class; unknown headers/identifiers decode as BtErr
module gen3_descramble_sequencer_os_classifier
  import gen3_descramble_sequencer_pkg::*;
(
  input  logic [1:0]  sync_header_i,
  input  logic [7:0]  sym0_i,
  output block_type_e block_type_o
);

  always_comb begin
    block_type_o = BtErr;
    case (sync_header_i)
      SyncData: block_type_o = BtData;
      SyncOs: begin
        case (sym0_i)
          OsIdEieos:                  block_type_o = BtEieos;
          OsIdSkp:                    block_type_o = BtSkp;
          OsIdTs1, OsIdTs2:           block_type_o = BtTs;
          OsIdEios, OsIdSds, OsIdFts: block_type_o = BtOtherOs;
          default:                    block_type_o = BtErr;
        endcase
      end
      default: block_type_o = BtErr;
    endcase
  end

endmodule

// File: rtl/gen3_descramble_sequencer.sv
// RX descrambler sequencer.
// Tracks 128b/130b block boundaries and symbol position, classifies each block
// and drives per-lane LFSR advance / descramble enable plus the LFSR reseed
// pulse. For gen < 3 it applies 8b/10b rules (COM reseed, SKP hold, K bypass).
// Ports: clk, reset (sync, active-low), bus (slave modport: PIPE RX in,
// lfsr_sel/advance/descramble_en/lfsr_reset/block_type/symbol_index/block_error out).
module gen3_descramble_sequencer
  import gen3_descramble_sequencer_pkg::*;
#(
  parameter int unsigned SymPerBlockP = SymPerBlock,
  parameter int unsigned BlkCntWP     = BlkCntW
) (
  input logic                         clk,
  input logic                         reset,
  gen3_descramble_sequencer_if.slave  bus
);

  localparam logic [BlkCntWP:0] BlockEnd = (BlkCntWP + 1)'(SymPerBlockP);

  state_e                state_q, state_d;
  logic [BlkCntWP-1:0]   idx_q, idx_d;
  logic [5:0]            width_q, width_d;
  block_type_e           bt_q, bt_d;
  logic                  lfsr_reset_q, lfsr_reset_d;
  logic                  block_error_q, block_error_d;
  logic [2:0]            gen_q;

  block_type_e           dec_type;
  block_type_e           cur_type;
  logic                  gen3_mode;
  logic                  in_block;
  logic                  start_beat;
  logic                  beat_active;
  logic                  last_beat;
  logic                  com_seen;
  logic [5:0]            eff_width;
  logic [2:0]            n_lanes;
  logic [3:0]            mask;
  logic [BlkCntWP-1:0]   base_idx;
  logic [BlkCntWP:0]     idx_sum;
  logic [3:0]            adv;
  logic [3:0]            en;
  logic [7:0]            lane_sym;

  gen3_descramble_sequencer_os_classifier u_os_classifier (
    .sync_header_i (bus.pipe_sync_header),
    .sym0_i        (bus.pipe_data[7:0]),
    .block_type_o  (dec_type)
  );

  // Beat decode and lane controls.
  always_comb begin
    gen3_mode = (bus.gen >= 3'd3);
    // A generation change abandons the block for this beat already.
    in_block    = (state_q == StInBlock) && (bus.gen == gen_q);
    start_beat  = gen3_mode && bus.pipe_data_valid && bus.pipe_start_block;
    // Width is frozen for a running block; a start beat brings a new width.
    eff_width   = (in_block && !start_beat) ? width_q : bus.pipe_width;
    n_lanes     = lanes_of_width(eff_width);
    mask        = lane_mask(n_lanes);
    cur_type    = start_beat ? dec_type : bt_q;
    base_idx    = (start_beat || !in_block) ? '0 : idx_q;
    idx_sum     = {1'b0, base_idx} + {{(BlkCntWP - 2){1'b0}}, n_lanes};
    last_beat   = (idx_sum == BlockEnd);
    beat_active = bus.pipe_data_valid && (start_beat || in_block);

    adv      = '0;
    en       = '0;
    com_seen = 1'b0;
    lane_sym = '0;
    for (int i = 0; i < 4; i++) begin
      if (gen3_mode) begin
        if (beat_active && mask[i]) begin
          adv[i] = (cur_type != BtSkp) && (cur_type != BtNone);
          // TS symbol 0 (the identifier) is passed through unscrambled.
          en[i]  = (cur_type == BtData) ||
                   ((cur_type == BtTs) && ((base_idx != '0) || (i != 0)));
        end
      end else if (bus.pipe_data_valid && mask[i]) begin
        lane_sym = bus.pipe_data[8*i +: 8];
        adv[i]   = !(bus.pipe_data_k[i] && (lane_sym == KSkp));
        en[i]    = !bus.pipe_data_k[i];
        if (bus.pipe_data_k[i] && (lane_sym == KCom)) begin
          com_seen = 1'b1;
        end
      end
    end
    if (bus.turn_off) begin
      en = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    width_d       = width_q;
    bt_d          = bt_q;
    lfsr_reset_d  = 1'b0;
    block_error_d = 1'b0;

    if (!gen3_mode) begin
      state_d      = StIdle;
      idx_d        = '0;
      lfsr_reset_d = com_seen;
    end else begin
      if (!in_block) begin
        state_d = StIdle;
        idx_d   = '0;
      end
      if (start_beat) begin
        width_d       = bus.pipe_width;
        bt_d          = dec_type;
        block_error_d = in_block || (dec_type == BtErr);
        if (last_beat) begin
          state_d      = StIdle;
          idx_d        = '0;
          lfsr_reset_d = (dec_type == BtEieos);
        end else begin
          state_d = StInBlock;
          idx_d   = idx_sum[BlkCntWP-1:0];
        end
      end else if (in_block && bus.pipe_data_valid) begin
        if (last_beat) begin
          state_d      = StIdle;
          idx_d        = '0;
          lfsr_reset_d = (bt_q == BtEieos);
        end else begin
          idx_d = idx_sum[BlkCntWP-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      width_q       <= 6'd8;
      bt_q          <= BtNone;
      lfsr_reset_q  <= 1'b0;
      block_error_q <= 1'b0;
      gen_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      width_q       <= width_d;
      bt_q          <= bt_d;
      lfsr_reset_q  <= lfsr_reset_d;
      block_error_q <= block_error_d;
      gen_q         <= bus.gen;
    end
  end

  assign bus.lfsr_sel      = lfsr_sel_of_width(eff_width);
  assign bus.advance       = adv;
  assign bus.descramble_en = en;
  assign bus.lfsr_reset    = lfsr_reset_q;
  assign bus.block_type    = bt_q;
  assign bus.symbol_index  = base_idx;
  assign bus.block_error   = block_error_q;

endmodule

// File: tb/tb_gen3_descramble_sequencer.sv
// Bench for gen3_descramble_sequencer: directed scenarios with literal
// expectations followed by randomized blocks, all outputs compared every
// cycle against a behavioural model of the block/lane rules.
module tb_gen3_descramble_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  bit   chk_on;

  gen3_descramble_sequencer_if bus ();

  gen3_descramble_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied with the next beat.
  logic [2:0] nxt_gen;
  logic [5:0] nxt_width;
  logic       nxt_turn_off;
  logic       nxt_reset;

  // Behavioural model state.
  bit model_in_block;
  int model_pos;
  int model_width;
  int model_type;
  int model_prev_gen;
  int model_lr;
  int model_be;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lanes(input int w);
    if (w == 8) return 1;
    if (w == 16) return 2;
    if (w == 32) return 4;
    return 0;
  endfunction

  function automatic int classify(input int sh, input int s0);
    if (sh == 1) return 1;
    if (sh != 2) return 6;
    case (s0)
      'h00: return 2;
      'hAA: return 3;
      'h1E, 'h2D: return 4;
      'h66, 'hE1, 'h55: return 5;
      default: return 6;
    endcase
  endfunction

  // Compare against the model, then advance the model with the inputs the
  // next rising edge will sample.
  always @(negedge clk) begin : compare
    int  g, w, n, cls, typ, pos, ea, ee, esel, sym, np;
    bit  g3, inblk, st, com;
    g     = int'(bus.gen);
    g3    = (g >= 3);
    inblk = model_in_block && (g == model_prev_gen);
    st    = g3 && bus.pipe_data_valid && bus.pipe_start_block;
    w     = (inblk && !st) ? model_width : int'(bus.pipe_width);
    n     = lanes(w);
    cls   = classify(int'(bus.pipe_sync_header), int'(bus.pipe_data[7:0]));
    typ   = st ? cls : model_type;
    pos   = (st || !inblk) ? 0 : model_pos;
    ea    = 0;
    ee    = 0;
    com   = 0;
    for (int i = 0; i < n; i++) begin
      sym = int'((bus.pipe_data >> (8 * i)) & 32'hFF);
      if (g3) begin
        if (bus.pipe_data_valid && (st || inblk)) begin
          if (typ != 3 && typ != 0) ea |= (1 << i);
          if (typ == 1 || (typ == 4 && pos + i != 0)) ee |= (1 << i);
        end
      end else if (bus.pipe_data_valid) begin
        if (!(bus.pipe_data_k[i] && sym == 'h1C)) ea |= (1 << i);
        if (!bus.pipe_data_k[i]) ee |= (1 << i);
        if (bus.pipe_data_k[i] && sym == 'hBC) com = 1;
      end
    end
    if (bus.turn_off) ee = 0;
    esel = (w == 16) ? 1 : (w == 32) ? 2 : 0;

    if (chk_on) begin
      chk("advance", int'(bus.advance), ea);
      chk("descramble_en", int'(bus.descramble_en), ee);
      chk("lfsr_sel", int'(bus.lfsr_sel), esel);
      chk("symbol_index", int'(bus.symbol_index), pos);
      chk("block_type", int'(bus.block_type), model_type);
      chk("lfsr_reset", int'(bus.lfsr_reset), model_lr);
      chk("block_error", int'(bus.block_error), model_be);
    end

    if (!reset) begin
      chk_on         = 1;
      model_in_block = 0;
      model_pos      = 0;
      model_width    = 8;
      model_type     = 0;
      model_prev_gen = 0;
      model_lr       = 0;
      model_be       = 0;
    end else if (chk_on) begin
      model_prev_gen = g;
      model_lr       = 0;
      model_be       = 0;
      if (!g3) begin
        model_in_block = 0;
        model_pos      = 0;
        model_lr       = com;
      end else begin
        if (!inblk) begin
          model_in_block = 0;
          model_pos      = 0;
        end
        if (st) begin
          model_width = int'(bus.pipe_width);
          model_type  = cls;
          model_be    = (inblk || cls == 6);
          if (n == 16) begin
            model_in_block = 0;
            model_pos      = 0;
          end else begin
            model_in_block = 1;
            model_pos      = n;
          end
        end else if (inblk && bus.pipe_data_valid) begin
          np = model_pos + n;
          if (np == 16) begin
            model_in_block = 0;
            model_pos      = 0;
            model_lr       = (model_type == 2);
          end else begin
            model_pos = np;
          end
        end
      end
    end
  end

  task automatic step(input bit v, input bit st, input logic [1:0] sh,
                      input logic [31:0] d, input logic [3:0] k);
    @(posedge clk);
    #1;
    reset                = nxt_reset;
    bus.gen              = nxt_gen;
    bus.pipe_width       = nxt_width;
    bus.turn_off         = nxt_turn_off;
    bus.pipe_data_valid  = v;
    bus.pipe_start_block = st;
    bus.pipe_sync_header = sh;
    bus.pipe_data        = d;
    bus.pipe_data_k      = k;
  endtask

  // Literal checks taken mid-cycle after a step.
  task automatic lit(input string name, input int adv, input int en, input int idx);
    #2;
    chk({name, ".adv"}, int'(bus.advance), adv);
    chk({name, ".en"}, int'(bus.descramble_en), en);
    chk({name, ".idx"}, int'(bus.symbol_index), idx);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return 8'hBC;
      1:       return 8'h1C;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0]  os_ids [8];
    logic [31:0] d;
    logic [1:0]  sh;
    int          r, w, nb;
    bit          st;
    os_ids = '{8'h00, 8'hAA, 8'h1E, 8'h2D, 8'h66, 8'hE1, 8'h55, 8'h7B};
    n_cmp = 0;
    n_bad = 0;
    chk_on = 0;
    nxt_gen = 3'd3;
    nxt_width = 6'd32;
    nxt_turn_off = 1'b0;
    nxt_reset = 1'b0;
    reset = 1'b0;
    bus.gen = 3'd3;
    bus.pipe_width = 6'd32;
    bus.turn_off = 1'b0;
    bus.pipe_data_valid = 1'b0;
    bus.pipe_start_block = 1'b0;
    bus.pipe_sync_header = 2'b00;
    bus.pipe_data = '0;
    bus.pipe_data_k = '0;
    repeat (3) step(0, 0, 2'b00, 32'h0, 4'h0);
    nxt_reset = 1'b1;

    // Reset state.
    step(0, 0, 2'b00, 32'h0, 4'h0);
    #2;
    chk("rst.block_type", int'(bus.block_type), 0);
    chk("rst.lfsr_reset", int'(bus.lfsr_reset), 0);

    // Gen3 x32 data block.
    step(1, 1, 2'b01, 32'h1234_5678, 4'h0); lit("data0", 'hF, 'hF, 0);
    step(1, 0, 2'b01, 32'h9ABC_DEF0, 4'h0); lit("data1", 'hF, 'hF, 4);
    chk("data.block_type", int'(bus.block_type), 1);
    step(1, 0, 2'b01, 32'h1111_2222, 4'h0); lit("data2", 'hF, 'hF, 8);
    step(1, 0, 2'b01, 32'h3333_4444, 4'h0); lit("data3", 'hF, 'hF, 12);
    step(1, 0, 2'b01, 32'h5555_6666, 4'h0); lit("data.idle", 0, 0, 0);

    // Gen3 x8 TS1.
    nxt_width = 6'd8;
    step(1, 1, 2'b10, 32'h0000_001E, 4'h0); lit("ts0", 1, 0, 0);
    for (int b = 1; b < 16; b++) begin
      step(1, 0, 2'b10, 32'h0000_004A, 4'h0);
      if (b == 1 || b == 15) lit("ts", 1, 1, b);
    end

    // Gen3 x16 EIEOS.
    nxt_width = 6'd16;
    for (int b = 0; b < 8; b++) begin
      step(1, (b == 0), 2'b10, 32'h0000_FF00, 4'h0);
      if (b == 0 || b == 7) lit("eieos", 3, 0, 2 * b);
    end
    step(0, 0, 2'b00, 32'h0, 4'h0);
    #2 chk("eieos.lfsr_reset", int'(bus.lfsr_reset), 1);
    step(0, 0, 2'b00, 32'h0, 4'h0);
    #2 chk("eieos.lfsr_reset_end", int'(bus.lfsr_reset), 0);

    // Gen3 x32 SKP, interrupted at symbol 8 by a data block.
    nxt_width = 6'd32;
    step(1, 1, 2'b10, 32'h0000_00AA, 4'h0); lit("skp0", 0, 0, 0);
    step(1, 0, 2'b10, 32'h0000_00AA, 4'h0); lit("skp1", 0, 0, 4);
    step(1, 1, 2'b01, 32'h0000_0000, 4'h0); lit("restart", 'hF, 'hF, 0);
    step(1, 0, 2'b01, 32'h0, 4'h0);
    #2;
    chk("restart.block_error", int'(bus.block_error), 1);
    chk("restart.block_type", int'(bus.block_type), 1);
    step(1, 0, 2'b01, 32'h0, 4'h0);
    step(1, 0, 2'b01, 32'h0, 4'h0);

    // Gen2 x16: COM in lane 0, then SKP in lane 1.
    nxt_gen = 3'd2;
    nxt_width = 6'd16;
    step(1, 0, 2'b00, 32'h0000_45BC, 4'h1); lit("g2com", 3, 2, 0);
    step(1, 0, 2'b00, 32'h0000_1C00, 4'h2); lit("g2skp", 1, 1, 0);
    chk("g2.lfsr_reset", int'(bus.lfsr_reset), 1);

    // Reset in the middle of a block.
    nxt_gen = 3'd3;
    nxt_width = 6'd32;
    step(1, 1, 2'b01, 32'h0, 4'h0);
    nxt_reset = 1'b0;
    step(0, 0, 2'b00, 32'h0, 4'h0);
    nxt_reset = 1'b1;
    step(1, 0, 2'b01, 32'h0, 4'h0); lit("postrst", 0, 0, 0);
    chk("postrst.block_type", int'(bus.block_type), 0);

    // Randomized blocks.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      nxt_gen = (r < 6) ? 3'd3 : (r < 8) ? 3'd4 : (r == 8) ? 3'd2 : 3'd1;
      r = $urandom_range(0, 19);
      w = (r < 6) ? 8 : (r < 12) ? 16 : (r < 19) ? 32 : 24;
      nxt_width = 6'(w);
      nxt_turn_off = ($urandom_range(0, 9) == 0);
      nb = (lanes(w) == 0) ? 3 : 16 / lanes(w);
      for (int b = 0; b < nb; b++) begin
        for (int gap = 0; gap < 2 && $urandom_range(0, 4) == 0; gap++) begin
          step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
               4'($urandom_range(0, 15)));
        end
        st = (b == 0) || ($urandom_range(0, 39) == 0);
        r = $urandom_range(0, 19);
        sh = (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'($urandom_range(0, 3));
        d = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
        if (st && sh == 2'b10) d[7:0] = os_ids[$urandom_range(0, 7)];
        if ($urandom_range(0, 49) == 0) nxt_gen = 3'($urandom_range(1, 4));
        if ($urandom_range(0, 49) == 0) nxt_width = 6'(8 << $urandom_range(0, 2));
        nxt_reset = ($urandom_range(0, 99) != 0);
        step(1, st, sh, d, 4'($urandom_range(0, 15)));
      end
      nxt_reset = 1'b1;
    end

    repeat (3) step(0, 0, 2'b00, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
